// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan accelerator.
package scan_pkg;

  typedef enum logic [1:0] {
    SUM_INC = 2'd0,
    SUM_EXC = 2'd1,
    MAX_S   = 2'd2
  } scan_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Raw mode code 3 is an alias of the inclusive sum.
  function automatic scan_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    decode_mode = SUM_EXC;
      2'd2:    decode_mode = MAX_S;
      default: decode_mode = SUM_INC;
    endcase
  endfunction

endpackage

// File: rtl/scan_accel_if.sv
// Control/status and host memory port of the scan accelerator.
interface scan_accel_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   end_addr;
  logic [DATA_W-1:0] init_acc;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              host_sel;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output start, start_addr, end_addr, init_acc, mode,
    output host_sel, host_we, host_addr, host_wdata,
    input  busy, done, result, host_rdata
  );

  modport slave (
    input  start, start_addr, end_addr, init_acc, mode,
    input  host_sel, host_we, host_addr, host_wdata,
    output busy, done, result, host_rdata
  );
endinterface

// File: rtl/scan_mem.sv
// Simple dual-port RAM: one write port, one read port with registered address.
module scan_mem #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_raddr;

  // Write port and read-address register.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_raddr <= i_raddr;
  end

  assign o_rdata = r_mem[r_raddr];
endmodule

// File: rtl/scan_accel.sv
// In-place prefix scan engine, one element per clock, over a local RAM.
module scan_accel
  import scan_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_accel_if.slave  bus
);
  scan_state_e       r_state, w_state_next;
  scan_mode_e        r_mode;
  logic [ADDR_W:0]   r_addr, r_end, w_addr_inc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_vld;
  logic              r_host_rd;
  logic [DATA_W-1:0] r_acc, r_result;
  logic [DATA_W-1:0] w_rdata, w_acc_new, w_eng_wdata;
  logic              w_empty, w_host_own;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr, w_mem_raddr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_addr_inc = r_addr + {{ADDR_W{1'b0}}, 1'b1};
  assign w_empty    = ({1'b0, bus.start_addr} >= bus.end_addr);
  assign w_host_own = (r_state == IDLE) && bus.host_sel;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = w_empty ? DONE : RUN;
      RUN:     if (w_addr_inc == r_end) w_state_next = DRAIN;
      DRAIN:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: r_vld marks a cycle where read data returns and must be written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_end     <= '0;
      r_wr_addr <= '0;
      r_vld     <= 1'b0;
      r_host_rd <= 1'b0;
      r_acc     <= '0;
      r_mode    <= SUM_INC;
      r_result  <= '0;
    end else begin
      r_vld     <= (r_state == RUN);
      r_host_rd <= w_host_own;
      if (r_state == IDLE && bus.start) begin
        r_addr <= {1'b0, bus.start_addr};
        r_end  <= bus.end_addr;
        r_acc  <= bus.init_acc;
        r_mode <= decode_mode(bus.mode);
        if (w_empty) r_result <= bus.init_acc;
      end
      if (r_state == RUN) begin
        r_addr    <= w_addr_inc;
        r_wr_addr <= r_addr[ADDR_W-1:0];
      end
      if (r_vld) r_acc <= w_acc_new;
      if (r_state == DRAIN) r_result <= w_acc_new;
    end
  end

  // Scan arithmetic on the element returned this cycle.
  always_comb begin
    w_acc_new   = r_acc + w_rdata;
    w_eng_wdata = w_acc_new;
    case (r_mode)
      SUM_EXC: w_eng_wdata = r_acc;
      MAX_S: begin
        w_acc_new   = ($signed(w_rdata) > $signed(r_acc)) ? w_rdata : r_acc;
        w_eng_wdata = w_acc_new;
      end
      default: ;
    endcase
  end

  // Memory port mux: engine owns it outside IDLE, host only in IDLE with host_sel.
  always_comb begin
    w_mem_we    = r_vld || (w_host_own && bus.host_we);
    w_mem_waddr = r_vld ? r_wr_addr : bus.host_addr;
    w_mem_wdata = r_vld ? w_eng_wdata : bus.host_wdata;
    w_mem_raddr = (r_state == RUN) ? r_addr[ADDR_W-1:0] : bus.host_addr;
  end

  scan_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_rdata)
  );

  assign bus.busy       = (r_state == RUN) || (r_state == DRAIN);
  assign bus.done       = (r_state == DONE);
  assign bus.result     = r_result;
  assign bus.host_rdata = (r_state == IDLE && r_host_rd) ? w_rdata : '0;
endmodule

// File: doc/scan_accel.md
Name: scan_accel

Overview:
- Parametrised in-place scan (prefix) engine over a local array memory; successor to the fixed 64-bit/1000-element accumulate loop.
- Adds configurable data/address width, a programmable [start,end) range, three scan modes, and a start/done handshake.
- Fully pipelined at one element per clock instead of a multi-state loop per element.
- A host port owns the memory while the engine is idle, for load and readback.

Parameters:
- DATA_W, 64, element and accumulator width (signed).
- ADDR_W, 10, memory address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- start_addr  in  ADDR_W  first element index.
- end_addr  in  ADDR_W+1  exclusive bound; may equal DEPTH.
- init_acc  in  DATA_W  initial accumulator value.
- mode  in  2  scan mode: 0 inclusive sum, 1 exclusive sum, 2 signed running max, 3 treated as 0.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  final accumulator; held until the next start.
- host_sel  in  1  host owns the memory (honoured only in IDLE).
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data; 1-cycle latency.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; busy=0, done=0, result=0. Memory contents are not reset.
- Memory: simple dual-port (1 write, 1 read). Read address is registered, so read latency is 1 cycle. Write-first is not required; the engine never reads and writes the same address in one cycle.
- States:
  - IDLE: on start=1, latch start_addr, end_addr, mode, init_acc.
    - If start_addr >= end_addr, go to DONE.
    - Otherwise go to RUN.
    - start outside IDLE is ignored.
  - RUN: issue a read of addr a each cycle, from start_addr to end_addr-1. One cycle later, compute the new value and write it back to a.
    - After issuing the last read, go to DRAIN.
  - DRAIN: perform the final write, then go to DONE.
  - DONE: done=1 for exactly one cycle, result=acc, busy=0, then return to IDLE.
- Latency: cycle 0 is the edge at which start is sampled. For N=end-start elements, read k issues at cycle k+1 and write k occurs at cycle k+2. The last write is at cycle N+1 and done is high in cycle N+2.
- Empty range: done is high in cycle 1, result=init_acc, no memory writes.
- Mode arithmetic (x = read element):
  - Inclusive: acc' = acc + x, written value = acc'.
  - Exclusive: written value = acc, acc' = acc + x.
  - Max: acc' = signed max(acc, x), written value = acc'.
  - Sums wrap modulo 2**DATA_W; no saturation and no overflow flag.
- Address wrap: end_addr = DEPTH is legal. The internal address counter is ADDR_W+1 bits and compares against end_addr.
- Host port:
  - In IDLE with host_sel=1, host_addr/host_we/host_wdata drive the memory.
  - Outside IDLE, host writes are dropped and host_rdata = 0.
  - With host_sel=0 in IDLE, the memory is quiescent (no writes).
- Reset mid-run: aborts immediately to IDLE with no done pulse. Partially written memory is left as is.

Decomposition:
- Package scan_pkg: typedef scan_mode_e (SUM_INC, SUM_EXC, MAX_S), typedef scan_state_e (IDLE, RUN, DRAIN, DONE), and the mode decode function.
- Sub-module scan_mem: parametrised simple dual-port RAM (DATA_W, ADDR_W) with registered read address. Port muxing between host and engine stays in scan_accel.

Test Plan:
- Host writes mem[0..9] = 1..10, then start(start=0, end=10, init=0, mode=0). Required: done in cycle 12, result=55, readback gives 1,3,6,10,...,55.
- Same load, mode=1, init=100. Required: mem = 100,101,103,...,145, result=155, mem[10] untouched.
- mem[4..7] = -5, 3, -9, 7, mode=2, init=-100, range [4,8). Required: mem = -5,3,3,7, result=7.
- start_addr=5, end_addr=5. Required: done in cycle 1, result=init_acc, no writes (mem unchanged on readback).
- Full range [0,1024), all entries = 2**63-1, mode=0, init=0. Required: wrap-around sums, result = -1024 mod 2**64, done in cycle 1026. A second start pulse during RUN is ignored.
- Assert rst_n low at cycle 5 of a 10-element run. Required: busy=0, done=0, result=0 immediately. Elements 0..3 updated, the rest original. A fresh start then completes normally.
